// File: rtl/csi_ppi_hs_tx_feeder_if.sv
// Bundle of the feeder's control, CSI FIFO and data-lane Tx PPI signals.
// The master modport is the feeder itself; slave is the surrounding logic.
interface csi_ppi_hs_tx_feeder_if #(
  parameter int WORD_BYTES = 1,
  parameter int LEN_W      = 16
);
  logic                    Enable;
  logic                    Start;
  logic [LEN_W-1:0]        BurstSize;
  logic                    Busy;
  logic                    Done;
  logic                    UnderrunErr;
  logic                    FifoEmpty;
  logic [8*WORD_BYTES-1:0] FifoData;
  logic                    FifoPop;
  logic                    TxRequestHS;
  logic [8*WORD_BYTES-1:0] TxDataHS;
  logic [3:0]              TxWordValidHS;
  logic                    TxReadyHS;
  logic                    Stopstate;

  modport master (
    input  Enable, Start, BurstSize, FifoEmpty, FifoData, TxReadyHS, Stopstate,
    output Busy, Done, UnderrunErr, FifoPop, TxRequestHS, TxDataHS, TxWordValidHS
  );

  modport slave (
    output Enable, Start, BurstSize, FifoEmpty, FifoData, TxReadyHS, Stopstate,
    input  Busy, Done, UnderrunErr, FifoPop, TxRequestHS, TxDataHS, TxWordValidHS
  );
endinterface

// File: rtl/csi_ppi_hs_tx_feeder.sv
// HS transmit feeder: drains CSI packet bytes from a FWFT FIFO through a one-word
// holding register onto the data-lane Tx PPI, one burst per accepted Start.
module csi_ppi_hs_tx_feeder #(
  parameter int WORD_BYTES = 1,
  parameter int LEN_W      = 16
) (
  input  logic                   TxWordClkHS,
  input  logic                   ResetN,
  csi_ppi_hs_tx_feeder_if.master bus
);
  localparam int               DW        = 8 * WORD_BYTES;
  localparam logic [LEN_W-1:0] WB_L      = LEN_W'(WORD_BYTES);
  localparam logic [3:0]       FULL_MASK = 4'((1 << WORD_BYTES) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND,
    S_WAIT_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_req, w_req_nxt;
  logic [DW-1:0]    r_hold, w_hold_nxt;
  logic             r_hold_vld, w_hold_vld_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic [LEN_W-1:0] r_wtf, w_wtf_nxt;
  logic             r_uerr, w_uerr_nxt;
  logic             r_done, w_done_nxt;

  logic             w_accept;
  logic             w_underrun;
  logic             w_fetch_phase;
  logic             w_pop;
  logic [LEN_W-1:0] w_rem_dec;
  logic [LEN_W-1:0] w_rem_after;
  logic [3:0]       w_mask;

  function automatic logic [LEN_W-1:0] words_for(input logic [LEN_W-1:0] n);
    logic [LEN_W:0] sum;
    sum = {1'b0, n} + (LEN_W+1)'(WORD_BYTES - 1);
    return LEN_W'(sum / (LEN_W+1)'(WORD_BYTES));
  endfunction

  // A short tail (rem < WORD_BYTES <= 4) always fits in two bits.
  function automatic logic [3:0] lane_mask(input logic [LEN_W-1:0] rem);
    if (rem >= WB_L) return FULL_MASK;
    return (4'd1 << rem[1:0]) - 4'd1;
  endfunction

  assign w_accept      = r_req && bus.TxReadyHS && r_hold_vld;
  assign w_underrun    = (r_state == S_SEND) && bus.TxReadyHS && !r_hold_vld && (r_rem != '0);
  assign w_fetch_phase = ((r_state == S_REQ) || (r_state == S_SEND)) && bus.Enable;
  // Pop is suppressed on the underrun cycle so an abandoned burst leaves the FIFO untouched.
  assign w_pop         = w_fetch_phase && !w_underrun && !bus.FifoEmpty && (r_wtf != '0) &&
                         (!r_hold_vld || w_accept);
  assign w_rem_dec     = (r_rem >= WB_L) ? WB_L : r_rem;
  assign w_rem_after   = r_rem - w_rem_dec;
  assign w_mask        = (r_req && r_hold_vld) ? lane_mask(r_rem) : 4'd0;

  assign bus.TxRequestHS   = r_req;
  assign bus.TxDataHS      = r_hold;
  assign bus.TxWordValidHS = w_mask;
  assign bus.FifoPop       = w_pop;
  assign bus.Busy          = (r_state != S_IDLE);
  assign bus.Done          = r_done;
  assign bus.UnderrunErr   = r_uerr;

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_rem_nxt      = r_rem;
    w_wtf_nxt      = r_wtf;
    w_uerr_nxt     = r_uerr;
    w_done_nxt     = 1'b0;

    // Pop and accept in the same cycle reload the register without a bubble.
    if (w_pop) begin
      w_hold_nxt     = bus.FifoData;
      w_hold_vld_nxt = 1'b1;
      w_wtf_nxt      = r_wtf - LEN_W'(1);
    end else if (w_accept) begin
      w_hold_vld_nxt = 1'b0;
    end
    if (w_accept) w_rem_nxt = w_rem_after;

    case (r_state)
      S_IDLE: begin
        if (bus.Start && bus.Enable && (bus.BurstSize != '0)) begin
          w_state_nxt    = S_REQ;
          w_req_nxt      = 1'b1;
          w_rem_nxt      = bus.BurstSize;
          w_wtf_nxt      = words_for(bus.BurstSize);
          w_uerr_nxt     = 1'b0;
          w_hold_vld_nxt = 1'b0;
        end
      end
      S_REQ: begin
        // A burst no longer than one word finishes on its first accept.
        if (w_accept) begin
          if (w_rem_after == '0) begin
            w_state_nxt = S_WAIT_STOP;
            w_req_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (w_accept && (w_rem_after == '0)) begin
          w_state_nxt = S_WAIT_STOP;
          w_req_nxt   = 1'b0;
        end else if (w_underrun) begin
          w_state_nxt = S_WAIT_STOP;
          w_req_nxt   = 1'b0;
          w_uerr_nxt  = 1'b1;
        end
      end
      S_WAIT_STOP: begin
        if (bus.Stopstate) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Enable low wins over everything; the sticky error survives an abort.
    if (!bus.Enable) begin
      w_state_nxt    = S_IDLE;
      w_req_nxt      = 1'b0;
      w_hold_vld_nxt = 1'b0;
      w_done_nxt     = 1'b0;
    end
  end

  always_ff @(posedge TxWordClkHS or negedge ResetN) begin
    if (!ResetN) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_rem      <= '0;
      r_wtf      <= '0;
      r_uerr     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_rem      <= w_rem_nxt;
      r_wtf      <= w_wtf_nxt;
      r_uerr     <= w_uerr_nxt;
      r_done     <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_csi_ppi_hs_tx_feeder.sv
// Bench for csi_ppi_hs_tx_feeder: a 4-byte-word and a 1-byte-word instance,
// FIFO models, and a scoreboard of expected PPI words checked on every accept.
module tb_csi_ppi_hs_tx_feeder;
  logic clk;
  logic rst_n;

  csi_ppi_hs_tx_feeder_if #(.WORD_BYTES(4), .LEN_W(16)) b4 ();
  csi_ppi_hs_tx_feeder_if #(.WORD_BYTES(1), .LEN_W(16)) b1 ();

  csi_ppi_hs_tx_feeder #(.WORD_BYTES(4), .LEN_W(16)) u_dut4 (
    .TxWordClkHS (clk),
    .ResetN      (rst_n),
    .bus         (b4.master)
  );
  csi_ppi_hs_tx_feeder #(.WORD_BYTES(1), .LEN_W(16)) u_dut1 (
    .TxWordClkHS (clk),
    .ResetN      (rst_n),
    .bus         (b1.master)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  m;
  } sb_t;

  typedef struct {
    int   burst;
    int   nw;
    int   dly;
    int   pops;
    int   acc;
    logic uerr;
    int   left;
  } vec_t;

  logic [31:0] fq4[$];
  logic [7:0]  fq1[$];
  sb_t         sb4[$];
  sb_t         sb1[$];
  logic [31:0] tmp4;
  logic [7:0]  tmp1;
  logic        pp4, pp1;
  int          cnt_pop[2], cnt_acc[2], cnt_done[2], last_acc[2], fall_cyc[2];
  logic        prev_req[2];
  int          cyc;
  int          total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(input int rem, input int wb);
    if (rem >= wb) return 4'((1 << wb) - 1);
    return 4'((1 << rem) - 1);
  endfunction

  function automatic logic f_req(input int k);
    return (k == 0) ? b4.TxRequestHS : b1.TxRequestHS;
  endfunction
  function automatic logic f_done(input int k);
    return (k == 0) ? b4.Done : b1.Done;
  endfunction
  function automatic logic f_busy(input int k);
    return (k == 0) ? b4.Busy : b1.Busy;
  endfunction
  function automatic logic f_uerr(input int k);
    return (k == 0) ? b4.UnderrunErr : b1.UnderrunErr;
  endfunction

  task automatic set_start(input int k, input logic st, input logic [15:0] sz);
    if (k == 0) begin b4.Start = st; b4.BurstSize = sz; end
    else        begin b1.Start = st; b1.BurstSize = sz; end
  endtask
  task automatic set_rdy(input int k, input logic v);
    if (k == 0) b4.TxReadyHS = v; else b1.TxReadyHS = v;
  endtask
  task automatic set_stop(input int k, input logic v);
    if (k == 0) b4.Stopstate = v; else b1.Stopstate = v;
  endtask
  task automatic set_en(input int k, input logic v);
    if (k == 0) b4.Enable = v; else b1.Enable = v;
  endtask

  task automatic clr_cnt(input int k);
    cnt_pop[k] = 0; cnt_acc[k] = 0; cnt_done[k] = 0; last_acc[k] = 0; fall_cyc[k] = 0;
  endtask

  task automatic push4(input logic [31:0] w, input logic [3:0] m, input logic exp_acc);
    sb_t e;
    fq4.push_back(w);
    e.d = w; e.m = m;
    if (exp_acc) sb4.push_back(e);
  endtask
  task automatic push1(input logic [7:0] w);
    sb_t e;
    fq1.push_back(w);
    e.d = {24'd0, w}; e.m = 4'h1;
    sb1.push_back(e);
  endtask

  // Sampled one time unit before each rising edge; FIFO pops are applied on the next falling edge.
  task automatic mon(input int k);
    logic pop, req, rdy, dn;
    logic [3:0] m;
    logic [31:0] d;
    sb_t e;
    if (k == 0) begin
      pop = b4.FifoPop; req = b4.TxRequestHS; rdy = b4.TxReadyHS; dn = b4.Done;
      m = b4.TxWordValidHS; d = b4.TxDataHS; pp4 = pop;
    end else begin
      pop = b1.FifoPop; req = b1.TxRequestHS; rdy = b1.TxReadyHS; dn = b1.Done;
      m = b1.TxWordValidHS; d = {24'd0, b1.TxDataHS}; pp1 = pop;
    end
    if (pop) cnt_pop[k]++;
    if (dn) cnt_done[k]++;
    if (prev_req[k] && !req) fall_cyc[k] = cyc;
    prev_req[k] = req;
    if (req && rdy && (m != 4'd0)) begin
      cnt_acc[k]++;
      last_acc[k] = cyc;
      if ((k == 0 && sb4.size() == 0) || (k == 1 && sb1.size() == 0)) begin
        total++; bad++;
        $display("FAIL unexpected_accept k=%0d: actual=0x%0h required=none", k, d);
      end else begin
        e = (k == 0) ? sb4.pop_front() : sb1.pop_front();
        chk($sformatf("acc_data k=%0d", k), d, e.d);
        chk($sformatf("acc_mask k=%0d", k), 32'(m), 32'(e.m));
      end
    end
  endtask

  always @(negedge clk) begin
    if (pp4 && fq4.size() != 0) tmp4 = fq4.pop_front();
    if (pp1 && fq1.size() != 0) tmp1 = fq1.pop_front();
    pp4 = 1'b0; pp1 = 1'b0;
    b4.FifoEmpty = (fq4.size() == 0);
    b4.FifoData  = (fq4.size() != 0) ? fq4[0] : 32'd0;
    b1.FifoEmpty = (fq1.size() == 0);
    b1.FifoData  = (fq1.size() != 0) ? fq1[0] : 8'd0;
    #4;
    cyc++;
    if (rst_n) begin
      mon(0);
      mon(1);
    end else begin
      prev_req[0] = 1'b0; prev_req[1] = 1'b0;
    end
  end

  task automatic start_burst(input int k, input int burst);
    int n;
    set_start(k, 1'b1, 16'(burst));
    @(negedge clk);
    set_start(k, 1'b0, 16'd0);
    n = 0;
    while (!f_req(k) && n < 10) begin @(negedge clk); n++; end
    chk("req_rise", 32'(f_req(k)), 32'd1);
  endtask

  task automatic go_burst(input int k, input int dly, output int lat);
    int n;
    repeat (dly) @(negedge clk);
    set_rdy(k, 1'b1);
    n = 0;
    while (f_req(k) && n < 200) begin @(negedge clk); n++; end
    chk("req_fall", 32'(f_req(k)), 32'd0);
    repeat (2) @(negedge clk);
    set_stop(k, 1'b1);
    lat = 0;
    while (!f_done(k) && lat < 10) begin @(negedge clk); lat++; end
    set_stop(k, 1'b0);
    set_rdy(k, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[5];
    int   lat, n;
    logic [31:0] w;

    tbl[0] = '{burst: 8,  nw: 2, dly: 3, pops: 2, acc: 2, uerr: 1'b0, left: 0};
    tbl[1] = '{burst: 6,  nw: 3, dly: 1, pops: 2, acc: 2, uerr: 1'b0, left: 1};
    tbl[2] = '{burst: 3,  nw: 1, dly: 0, pops: 1, acc: 1, uerr: 1'b0, left: 0};
    tbl[3] = '{burst: 12, nw: 2, dly: 0, pops: 2, acc: 2, uerr: 1'b1, left: 0};
    tbl[4] = '{burst: 5,  nw: 2, dly: 2, pops: 2, acc: 2, uerr: 1'b0, left: 0};

    total = 0; bad = 0; cyc = 0; pp4 = 1'b0; pp1 = 1'b0;
    prev_req[0] = 1'b0; prev_req[1] = 1'b0;
    clr_cnt(0); clr_cnt(1);
    set_en(0, 1'b1); set_en(1, 1'b1);
    set_start(0, 1'b0, 16'd0); set_start(1, 1'b0, 16'd0);
    set_rdy(0, 1'b0); set_rdy(1, 1'b0);
    set_stop(0, 1'b0); set_stop(1, 1'b0);
    b4.FifoEmpty = 1'b1; b4.FifoData = 32'd0;
    b1.FifoEmpty = 1'b1; b1.FifoData = 8'd0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req4",  32'(b4.TxRequestHS), 32'd0);
    chk("rst_data4", b4.TxDataHS, 32'd0);
    chk("rst_mask4", 32'(b4.TxWordValidHS), 32'd0);
    chk("rst_pop4",  32'(b4.FifoPop), 32'd0);
    chk("rst_busy4", 32'(b4.Busy), 32'd0);
    chk("rst_done4", 32'(b4.Done), 32'd0);
    chk("rst_uerr4", 32'(b4.UnderrunErr), 32'd0);
    chk("rst_req1",  32'(b1.TxRequestHS), 32'd0);
    chk("rst_data1", 32'(b1.TxDataHS), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      clr_cnt(0);
      for (int j = 0; j < tbl[i].nw; j++) begin
        w = $urandom;
        push4(w, exp_mask(tbl[i].burst - 4 * j, 4), j < tbl[i].acc);
      end
      @(negedge clk);
      start_burst(0, tbl[i].burst);
      go_burst(0, tbl[i].dly, lat);
      chk($sformatf("v%0d_pops", i), 32'(cnt_pop[0]), 32'(tbl[i].pops));
      chk($sformatf("v%0d_acc", i), 32'(cnt_acc[0]), 32'(tbl[i].acc));
      chk($sformatf("v%0d_uerr", i), 32'(b4.UnderrunErr), 32'(tbl[i].uerr));
      chk($sformatf("v%0d_left", i), 32'(fq4.size()), 32'(tbl[i].left));
      chk($sformatf("v%0d_sb_drain", i), 32'(sb4.size()), 32'd0);
      chk($sformatf("v%0d_done_cnt", i), 32'(cnt_done[0]), 32'd1);
      chk($sformatf("v%0d_done_lat", i), 32'(lat), 32'd1);
      if (!tbl[i].uerr)
        chk($sformatf("v%0d_req_fall_lat", i), 32'(fall_cyc[0] - last_acc[0]), 32'd1);
      fq4.delete(); sb4.delete();
      @(negedge clk);
    end

    // Byte-wide lane: B8,01,02,03,04 each with a single-bit mask.
    clr_cnt(1);
    push1(8'hB8); push1(8'h01); push1(8'h02); push1(8'h03); push1(8'h04);
    @(negedge clk);
    start_burst(1, 5);
    go_burst(1, 0, lat);
    chk("b1_acc", 32'(cnt_acc[1]), 32'd5);
    chk("b1_pops", 32'(cnt_pop[1]), 32'd5);
    chk("b1_uerr", 32'(b1.UnderrunErr), 32'd0);
    chk("b1_sb_drain", 32'(sb1.size()), 32'd0);
    chk("b1_done_cnt", 32'(cnt_done[1]), 32'd1);

    // Underrun on the byte lane, then the next Start clears the flag.
    clr_cnt(1);
    push1(8'h5A); push1(8'hA5);
    @(negedge clk);
    start_burst(1, 4);
    go_burst(1, 0, lat);
    chk("ur_uerr", 32'(b1.UnderrunErr), 32'd1);
    chk("ur_acc", 32'(cnt_acc[1]), 32'd2);
    chk("ur_pops", 32'(cnt_pop[1]), 32'd2);
    chk("ur_done_cnt", 32'(cnt_done[1]), 32'd1);
    chk("ur_done_lat", 32'(lat), 32'd1);
    clr_cnt(1);
    push1(8'h77);
    @(negedge clk);
    start_burst(1, 1);
    chk("ur_clear_on_start", 32'(b1.UnderrunErr), 32'd0);
    go_burst(1, 0, lat);
    chk("ur_next_acc", 32'(cnt_acc[1]), 32'd1);
    chk("ur_next_sb_drain", 32'(sb1.size()), 32'd0);

    // Start with BurstSize=0 is ignored.
    clr_cnt(0);
    set_start(0, 1'b1, 16'd0);
    @(negedge clk);
    set_start(0, 1'b0, 16'd0);
    @(negedge clk);
    chk("zero_busy", 32'(f_busy(0)), 32'd0);
    chk("zero_req", 32'(f_req(0)), 32'd0);
    @(negedge clk);
    chk("zero_done", 32'(cnt_done[0]), 32'd0);

    // Start while busy must not reload the length.
    clr_cnt(0);
    w = $urandom; push4(w, 4'hF, 1'b1);
    w = $urandom; push4(w, 4'hF, 1'b1);
    @(negedge clk);
    start_burst(0, 8);
    @(negedge clk);
    set_start(0, 1'b1, 16'd4);
    @(negedge clk);
    set_start(0, 1'b0, 16'd0);
    chk("busy_start_busy", 32'(f_busy(0)), 32'd1);
    chk("busy_start_mask", 32'(b4.TxWordValidHS), 32'hF);
    go_burst(0, 0, lat);
    chk("busy_start_acc", 32'(cnt_acc[0]), 32'd2);
    chk("busy_start_pops", 32'(cnt_pop[0]), 32'd2);
    chk("busy_start_done", 32'(cnt_done[0]), 32'd1);
    chk("busy_start_sb", 32'(sb4.size()), 32'd0);

    // Enable dropped after the first of four words.
    clr_cnt(0);
    for (int j = 0; j < 4; j++) begin
      w = $urandom;
      push4(w, 4'hF, j == 0);
    end
    @(negedge clk);
    start_burst(0, 16);
    @(negedge clk);
    set_rdy(0, 1'b1);
    @(negedge clk);
    set_en(0, 1'b0);
    set_rdy(0, 1'b0);
    @(negedge clk);
    chk("en_req", 32'(f_req(0)), 32'd0);
    chk("en_busy", 32'(f_busy(0)), 32'd0);
    repeat (4) @(negedge clk);
    chk("en_pops", 32'(cnt_pop[0]), 32'd2);
    chk("en_acc", 32'(cnt_acc[0]), 32'd1);
    chk("en_done", 32'(cnt_done[0]), 32'd0);
    chk("en_left", 32'(fq4.size()), 32'd2);
    chk("en_sb", 32'(sb4.size()), 32'd0);
    set_en(0, 1'b1);
    fq4.delete();
    @(negedge clk);

    // Asynchronous reset in the middle of SEND.
    clr_cnt(0);
    for (int j = 0; j < 4; j++) begin
      w = $urandom;
      push4(w, 4'hF, 1'b1);
    end
    @(negedge clk);
    start_burst(0, 16);
    set_rdy(0, 1'b1);
    n = 0;
    while (cnt_acc[0] < 1 && n < 20) begin @(negedge clk); n++; end
    chk("ar_first_acc", 32'(cnt_acc[0] >= 1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req",  32'(b4.TxRequestHS), 32'd0);
    chk("ar_data", b4.TxDataHS, 32'd0);
    chk("ar_mask", 32'(b4.TxWordValidHS), 32'd0);
    chk("ar_pop",  32'(b4.FifoPop), 32'd0);
    chk("ar_busy", 32'(b4.Busy), 32'd0);
    chk("ar_done", 32'(b4.Done), 32'd0);
    chk("ar_uerr", 32'(b4.UnderrunErr), 32'd0);
    @(negedge clk);
    set_rdy(0, 1'b0);
    fq4.delete(); sb4.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
